// File: rtl/ex_stage.sv
// Execute stage: ADD/SUB ALU, BEQ resolution and a valid/ready result register.
// Define EX_PERF_CNT_EN to add the instruction and taken-branch counters.
module ex_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [6:0]      in_opcode,
  input  logic [3:0]      in_alu_ctrl,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [XLEN-1:0] in_imm,
  input  logic [REGW-1:0] in_rd,
  input  logic            in_reg_write,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_alu_result,
  output logic [XLEN-1:0] out_store_data,
  output logic [REGW-1:0] out_rd,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_target
`ifdef EX_PERF_CNT_EN
  ,
  output logic [31:0]     perf_instr_cnt,
  output logic [31:0]     perf_br_taken_cnt
`endif
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  typedef struct packed {
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] store;
    logic [REGW-1:0] rd;
    logic            rw;
    logic            mr;
    logic            mw;
    logic            br;
  } res_t;

  res_t            res_q, res_d;
  logic            sent_q;
  logic            accept;
  logic [XLEN-1:0] opb;
  logic [XLEN-1:0] diff;
  logic            is_beq;

  // Reset gating keeps every output low while rst is asserted.
  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready && !flush;

  assign is_beq = (in_opcode == OP_BEQ);
  assign opb    = (in_opcode == OP_R || is_beq) ? in_rs2_val : in_imm;
  assign diff   = in_rs1_val - opb;

  always_comb begin
    res_d       = '0;
    res_d.alu   = (in_alu_ctrl == ALU_SUB) ? diff : in_rs1_val + opb;
    res_d.store = in_rs2_val;
    res_d.rd    = in_rd;
    res_d.rw    = in_reg_write && !(in_opcode == OP_SW) && !is_beq;
    res_d.mr    = (in_opcode == OP_LW);
    res_d.mw    = (in_opcode == OP_SW);
    res_d.br    = is_beq && (diff == '0);
  end

  // Redirect fires once per taken BEQ; sent_q masks it across stall cycles.
  assign branch_taken = out_valid && res_q.br && !sent_q && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      res_q         <= '0;
      sent_q        <= 1'b0;
      branch_target <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      sent_q    <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      res_q     <= res_d;
      sent_q    <= 1'b0;
      if (res_d.br) branch_target <= in_pc + in_imm;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (branch_taken) sent_q <= 1'b1;
    end
  end

  assign out_alu_result = res_q.alu;
  assign out_store_data = res_q.store;
  assign out_rd         = res_q.rd;
  assign out_reg_write  = res_q.rw;
  assign out_mem_read   = res_q.mr;
  assign out_mem_write  = res_q.mw;

`ifdef EX_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_instr_cnt    <= '0;
      perf_br_taken_cnt <= '0;
    end else begin
      if (accept) perf_instr_cnt <= perf_instr_cnt + 32'd1;
      if (branch_taken) perf_br_taken_cnt <= perf_br_taken_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: driver pushes expected results, monitor pops on output handshake.
module tb_ex_stage;
  localparam int XLEN = 32;
  localparam int REGW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready;
  logic [XLEN-1:0] in_pc, in_rs1_val, in_rs2_val, in_imm;
  logic [6:0]      in_opcode;
  logic [3:0]      in_alu_ctrl;
  logic [REGW-1:0] in_rd;
  logic            in_reg_write, flush;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_alu_result, out_store_data;
  logic [REGW-1:0] out_rd;
  logic            out_reg_write, out_mem_read, out_mem_write;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
`ifdef EX_PERF_CNT_EN
  logic [31:0]     perf_instr_cnt, perf_br_taken_cnt;
`endif

  ex_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_opcode(in_opcode), .in_alu_ctrl(in_alu_ctrl), .in_rs1_val(in_rs1_val),
    .in_rs2_val(in_rs2_val), .in_imm(in_imm), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_result(out_alu_result), .out_store_data(out_store_data), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .branch_taken(branch_taken), .branch_target(branch_target)
`ifdef EX_PERF_CNT_EN
    , .perf_instr_cnt(perf_instr_cnt), .perf_br_taken_cnt(perf_br_taken_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] store;
    logic [REGW-1:0] rd;
    logic            rw, mr, mw;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails = 0;
  int   br_pulses = 0;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [31:0] pc, input logic [6:0] op, input logic [3:0] ctrl,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                      input logic [4:0] rd, input logic rw,
                      input logic [31:0] e_alu, input logic [31:0] e_st,
                      input logic e_rw, input logic e_mr, input logic e_mw);
    exp_t e;
    bit   acc = 0;
    int   n = 0;
    e.alu = e_alu; e.store = e_st; e.rd = rd; e.rw = e_rw; e.mr = e_mr; e.mw = e_mw;
    in_valid = 1'b1; in_pc = pc; in_opcode = op; in_alu_ctrl = ctrl;
    in_rs1_val = a; in_rs2_val = b; in_imm = imm; in_rd = rd; in_reg_write = rw;
    while (!acc && n < 50) begin
      @(negedge clk);
      if (in_ready && !flush) begin acc = 1; sb.push_back(e); end
      @(posedge clk); #1;
      n++;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  // Monitor: compare the presented result whenever the memory stage takes it.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_output", out_alu_result, 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("alu_result", out_alu_result, e.alu);
          check("store_data", out_store_data, e.store);
          check("rd", {27'd0, out_rd}, {27'd0, e.rd});
          check("flags rw/mr/mw", {29'd0, out_reg_write, out_mem_read, out_mem_write},
                {29'd0, e.rw, e.mr, e.mw});
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (branch_taken) br_pulses++;
    end
  end

  initial begin
    int brp0;
`ifdef EX_PERF_CNT_EN
    logic [31:0] pc0;
`endif
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_opcode = '0; in_alu_ctrl = '0; in_rs1_val = '0; in_rs2_val = '0;
    in_imm = '0; in_rd = '0; in_reg_write = 1'b0;
    #2;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset in_ready", {31'd0, in_ready}, 32'd0);
    check("reset alu_result", out_alu_result, 32'd0);
    check("reset branch", {31'd0, branch_taken}, 32'd0);
    #10 rst = 1'b0;
    #1 check("in_ready after reset", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // back-to-back ADD / SUB
    send(32'h0, OP_R, 4'b0000, 32'd5, 32'd7, 32'd0, 5'd1, 1'b1, 32'h0000000C, 32'd7, 1, 0, 0);
    send(32'h4, OP_R, 4'b0001, 32'd3, 32'd5, 32'd0, 5'd2, 1'b1, 32'hFFFFFFFE, 32'd5, 1, 0, 0);
    @(negedge clk);
    check("throughput out_valid", {31'd0, out_valid}, 32'd1);
    check("throughput sub", out_alu_result, 32'hFFFFFFFE);
    idle(1);

    // backpressure on ADDI
    out_ready = 1'b0;
    send(32'h8, OP_I, 4'b0000, 32'h10, 32'h99, 32'h4, 5'd3, 1'b1, 32'h14, 32'h99, 1, 0, 0);
    fork
      send(32'hC, OP_R, 4'b0000, 32'd1, 32'd1, 32'd0, 5'd4, 1'b1, 32'd2, 32'd1, 1, 0, 0);
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall hold alu", out_alu_result, 32'h14);
          check("stall in_ready", {31'd0, in_ready}, 32'd0);
          check("stall out_valid", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    idle(1);

    // taken BEQ under 2 stall cycles
    out_ready = 1'b0;
    brp0 = br_pulses;
    send(32'h100, OP_BEQ, 4'b0001, 32'd9, 32'd9, 32'h20, 5'd5, 1'b1, 32'd0, 32'd9, 0, 0, 0);
    @(negedge clk);
    check("beq taken pulse", {31'd0, branch_taken}, 32'd1);
    check("beq target", branch_target, 32'h120);
    check("beq reg_write", {31'd0, out_reg_write}, 32'd0);
    @(negedge clk);
    check("beq stall no pulse", {31'd0, branch_taken}, 32'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("beq drain no pulse", {31'd0, branch_taken}, 32'd0);
    idle(1);

    // not-taken BEQ then SW
    send(32'h104, OP_BEQ, 4'b0001, 32'd1, 32'd2, 32'h40, 5'd0, 1'b0, 32'hFFFFFFFF, 32'd2, 0, 0, 0);
    send(32'h108, OP_SW, 4'b0000, 32'h40, 32'hAB, 32'h8, 5'd6, 1'b1, 32'h48, 32'hAB, 0, 0, 1);
    idle(2);
    check("one redirect total", br_pulses - brp0, 32'd1);
    check("target holds", branch_target, 32'h120);

    // flush a held taken BEQ while new input is offered
    out_ready = 1'b0;
    send(32'h200, OP_BEQ, 4'b0001, 32'd5, 32'd5, 32'h10, 5'd0, 1'b0, 32'd0, 32'd5, 0, 0, 0);
`ifdef EX_PERF_CNT_EN
    pc0 = perf_instr_cnt;
`endif
    flush = 1'b1; in_valid = 1'b1; in_opcode = OP_R; in_rs1_val = 32'd3; in_rs2_val = 32'd3;
    @(negedge clk);
    check("flush no pulse", {31'd0, branch_taken}, 32'd0);
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    check("flush out_valid", {31'd0, out_valid}, 32'd0);
    check("flush redirect count", br_pulses - brp0, 32'd1);
`ifdef EX_PERF_CNT_EN
    check("flush perf_instr_cnt", perf_instr_cnt, pc0);
`endif
    out_ready = 1'b1;
    idle(2);
    check("post flush empty", {31'd0, out_valid}, 32'd0);

    // LW with an undefined ALU code behaves as ADD
    send(32'h300, OP_LW, 4'b0111, 32'h100, 32'h5, 32'hFFFFFFFC, 5'd7, 1'b1, 32'hFC, 32'h5, 1, 1, 0);
    idle(1);

    // asynchronous reset with a held instruction
    out_ready = 1'b0;
    send(32'h304, OP_R, 4'b0000, 32'd1, 32'd2, 32'd0, 5'd3, 1'b1, 32'd3, 32'd2, 1, 0, 0);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    check("async rst out_valid", {31'd0, out_valid}, 32'd0);
    check("async rst alu", out_alu_result, 32'd0);
    check("async rst rd/rw", {26'd0, out_rd, out_reg_write}, 32'd0);
    check("async rst target", branch_target, 32'd0);
`ifdef EX_PERF_CNT_EN
    check("async rst perf", perf_instr_cnt | perf_br_taken_cnt, 32'd0);
`endif
    sb.delete();
    @(posedge clk); #2 rst = 1'b0;
    #1 check("in_ready after release", {31'd0, in_ready}, 32'd1);
    idle(2);
    check("scoreboard drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
